// File: rtl/sha256_msg_padder_if.sv
// Padded schedule-word stream from the message padder to the compression stage.
interface sha256_msg_padder_if;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_index;
   logic [7:0]  w_block;
   logic        w_last;

   modport master (
      output w_valid,
      output w_data,
      output w_index,
      output w_block,
      output w_last,
      input  w_ready
   );

   modport slave (
      input  w_valid,
      input  w_data,
      input  w_index,
      input  w_block,
      input  w_last,
      output w_ready
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads NUM_OF_WORDS words from SRAM one at a time and streams them
// out followed by the 0x80000000 marker, zero fill and the 64-bit message bit length.
module sha256_msg_padder #(
   parameter int unsigned NUM_OF_WORDS = 20
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [15:0]                message_addr,
   output logic                       busy,
   output logic                       done,
   output logic                       mem_clk,
   output logic                       mem_we,
   output logic [15:0]                mem_addr,
   input  logic [31:0]                mem_read_data,
   sha256_msg_padder_if.master        w
);

   localparam int unsigned Blocks = (NUM_OF_WORDS + 2) / 16 + 1;
   localparam int unsigned Total  = 16 * Blocks;

   localparam logic [11:0] NumWords = 12'(NUM_OF_WORDS);
   localparam logic [11:0] LastPos  = 12'(Total - 1);
   localparam logic [31:0] SizeBits = 32'(NUM_OF_WORDS * 32);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StMem1 = 3'd1;
   localparam logic [2:0] StMem2 = 3'd2;
   localparam logic [2:0] StOut  = 3'd3;
   localparam logic [2:0] StPad  = 3'd4;
   localparam logic [2:0] StDone = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [11:0] pos_q, pos_d;
   logic [15:0] base_q, base_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [31:0] w_data_q, w_data_d;
   logic        w_valid_q, w_valid_d;

   logic        handshake;
   logic [11:0] pos_inc;

   // Padding content for a position past the message: marker, length low half, else zero.
   // The length upper half is always zero since SIZE is truncated to 32 bits.
   function automatic logic [31:0] pad_word(input logic [11:0] p);
      if (p == NumWords) begin
         return 32'h8000_0000;
      end else if (p == LastPos) begin
         return SizeBits;
      end else begin
         return 32'h0000_0000;
      end
   endfunction

   assign handshake = w_valid_q && w.w_ready;
   assign pos_inc   = pos_q + 12'd1;

   // Next-state logic: one outstanding SRAM read per message word, then pad words back to back.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      base_d     = base_q;
      mem_addr_d = mem_addr_q;
      w_data_d   = w_data_q;
      w_valid_d  = w_valid_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               base_d     = message_addr;
               mem_addr_d = message_addr;
               pos_d      = '0;
               state_d    = StMem1;
            end
         end
         StMem1: state_d = StMem2;
         StMem2: begin
            w_data_d  = mem_read_data;
            w_valid_d = 1'b1;
            state_d   = StOut;
         end
         StOut: begin
            if (handshake) begin
               pos_d = pos_inc;
               if (pos_inc < NumWords) begin
                  // Address arithmetic wraps modulo 2^16 by width.
                  mem_addr_d = base_q + {4'd0, pos_inc};
                  w_valid_d  = 1'b0;
                  state_d    = StMem1;
               end else begin
                  w_data_d = pad_word(pos_inc);
                  state_d  = StPad;
               end
            end
         end
         StPad: begin
            if (handshake) begin
               if (pos_q == LastPos) begin
                  w_valid_d = 1'b0;
                  state_d   = StDone;
               end else begin
                  pos_d    = pos_inc;
                  w_data_d = pad_word(pos_inc);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset abandons any job in flight and clears every output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         pos_q      <= '0;
         base_q     <= '0;
         mem_addr_q <= '0;
         w_data_q   <= '0;
         w_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         base_q     <= base_d;
         mem_addr_q <= mem_addr_d;
         w_data_q   <= w_data_d;
         w_valid_q  <= w_valid_d;
      end
   end

   // Outputs derive from registered state only, so they hold while the consumer stalls.
   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      mem_clk   = clk;
      mem_we    = 1'b0;
      mem_addr  = mem_addr_q;
      w.w_valid = w_valid_q;
      w.w_data  = w_data_q;
      w.w_index = pos_q[3:0];
      w.w_block = pos_q[11:4];
      w.w_last  = w_valid_q && (pos_q == LastPos);
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: three instances (N = 20, 13, 14) share one SRAM model; each job's
// stream is compared word by word against the padding rules and the cycle-count formula.
module tb_sha256_msg_padder;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic [31:0] mem [0:65535];

   logic [2:0]        start;
   logic [2:0][15:0]  maddr_i;
   logic [2:0]        rdy;
   logic [2:0]        busy;
   logic [2:0]        done;
   logic [2:0]        mclk;
   logic [2:0]        mwe;
   logic [2:0][15:0]  maddr_o;
   logic [2:0]        vld;
   logic [2:0][31:0]  wd;
   logic [2:0][3:0]   widx;
   logic [2:0][7:0]   wblk;
   logic [2:0]        wlast;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sha256_msg_padder_if wif ();
      logic [15:0] a;
      logic [31:0] rd;

      sha256_msg_padder #(
         .NUM_OF_WORDS(g == 0 ? 20 : (g == 1 ? 13 : 14))
      ) dut (
         .clk           (clk),
         .reset_n       (reset_n),
         .start         (start[g]),
         .message_addr  (maddr_i[g]),
         .busy          (busy[g]),
         .done          (done[g]),
         .mem_clk       (mclk[g]),
         .mem_we        (mwe[g]),
         .mem_addr      (a),
         .mem_read_data (rd),
         .w             (wif.master)
      );

      // Synchronous SRAM read port: address sampled on an edge, data seen by the next edge.
      always @(posedge clk) rd <= mem[a];

      assign wif.w_ready = rdy[g];
      assign maddr_o[g]  = a;
      assign vld[g]      = wif.w_valid;
      assign wd[g]       = wif.w_data;
      assign widx[g]     = wif.w_index;
      assign wblk[g]     = wif.w_block;
      assign wlast[g]    = wif.w_last;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int nw(input int g);
      return (g == 0) ? 20 : ((g == 1) ? 13 : 14);
   endfunction

   function automatic int total_of(input int n);
      return ((n + 2) / 16) * 16 + 16;
   endfunction

   // Reference content of padded word p for an n-word message at addr.
   function automatic logic [31:0] exp_word(input int n, input logic [15:0] addr, input int p);
      logic [15:0] a;
      a = addr + p[15:0];
      if (p < n) return mem[a];
      if (p == n) return 32'h8000_0000;
      if (p == total_of(n) - 1) return 32'(n * 32);
      return 32'h0;
   endfunction

   // mode 0: always ready; 1: 5-cycle stalls at positions st_a and st_b; 2: random ready.
   task automatic run_job(input int g, input logic [15:0] addr, input int mode, input int st_a,
                          input int st_b, input bit extra_start);
      int n, total, cyc, got, stall_left, stalls, done_cnt, done_cyc, first_v;
      bit trig_a, trig_b;
      n = nw(g);
      total = total_of(n);
      got = 0; stall_left = 0; stalls = 0; done_cnt = 0; done_cyc = -1; first_v = -1;
      trig_a = 1'b0; trig_b = 1'b0;
      @(posedge clk); #1;
      start[g] = 1'b1;
      maddr_i[g] = addr;
      rdy[g] = 1'b1;
      @(posedge clk); #1;
      start[g] = 1'b0;
      cyc = 0;
      while (cyc < 3000 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
         if (mode == 1) begin
            if (!trig_a && vld[g] && got == st_a) begin trig_a = 1'b1; stall_left = 5; end
            if (!trig_b && vld[g] && got == st_b) begin trig_b = 1'b1; stall_left = 5; end
            if (stall_left > 0) begin rdy[g] = 1'b0; stall_left--; end
            else rdy[g] = 1'b1;
         end else if (mode == 2) begin
            rdy[g] = ($urandom_range(0, 3) != 0);
         end else begin
            rdy[g] = 1'b1;
         end
         if (extra_start) start[g] = (cyc == 10);
         @(negedge clk);
         if (done[g]) begin done_cnt++; done_cyc = cyc; end
         if (vld[g]) begin
            if (first_v < 0) first_v = cyc;
            if (!rdy[g]) stalls++;
            if (got < total) begin
               check_eq($sformatf("n%0d@%04h w%0d data", n, addr, got), wd[g],
                        exp_word(n, addr, got));
               check_eq($sformatf("n%0d w%0d index", n, got), 32'(widx[g]), 32'(got % 16));
               check_eq($sformatf("n%0d w%0d block", n, got), 32'(wblk[g]), 32'(got / 16));
               check_eq($sformatf("n%0d w%0d last", n, got), 32'(wlast[g]),
                        32'(got == total - 1));
            end else begin
               check_eq($sformatf("n%0d overrun", n), 32'(got), 32'(total - 1));
            end
            if (rdy[g]) got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start[g] = 1'b0;
      rdy[g] = 1'b1;
      check_eq($sformatf("n%0d done pulses", n), 32'(done_cnt), 32'd1);
      check_eq($sformatf("n%0d done cycle", n), 32'(done_cyc), 32'(3 * n + total - n + stalls));
      check_eq($sformatf("n%0d word count", n), 32'(got), 32'(total));
      check_eq($sformatf("n%0d first valid", n), 32'(first_v), 32'd2);
      check_eq($sformatf("n%0d busy after", n), 32'(busy[g]), 32'd0);
      if (mode == 1) check_eq("stall cycles", 32'(stalls), 32'd10);
   endtask

   task automatic check_outputs_zero(input int g, input string tag);
      check_eq({tag, " busy"}, 32'(busy[g]), 32'd0);
      check_eq({tag, " done"}, 32'(done[g]), 32'd0);
      check_eq({tag, " mem_we"}, 32'(mwe[g]), 32'd0);
      check_eq({tag, " mem_addr"}, 32'(maddr_o[g]), 32'd0);
      check_eq({tag, " w_valid"}, 32'(vld[g]), 32'd0);
      check_eq({tag, " w_data"}, wd[g], 32'd0);
      check_eq({tag, " w_index"}, 32'(widx[g]), 32'd0);
      check_eq({tag, " w_block"}, 32'(wblk[g]), 32'd0);
      check_eq({tag, " w_last"}, 32'(wlast[g]), 32'd0);
   endtask

   initial begin
      logic [31:0] w;
      reset_n = 1'b0;
      start   = '0;
      maddr_i = '0;
      rdy     = '1;
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      w = 32'h0123_4675;
      for (int i = 0; i < 20; i++) begin
         mem[i] = w;
         w = {w[30:0], w[31]};
      end
      #12;
      for (int g = 0; g < 3; g++) check_outputs_zero(g, $sformatf("reset n%0d", nw(g)));
      @(negedge clk);
      check_eq("mem_clk low", 32'(mclk[0]), 32'(clk));
      @(posedge clk); #1;
      check_eq("mem_clk high", 32'(mclk[0]), 32'(clk));
      reset_n = 1'b1;

      // Baseline runs for each message length.
      run_job(0, 16'h0000, 0, -1, -1, 1'b0);
      run_job(1, 16'($urandom), 0, -1, -1, 1'b0);
      run_job(2, 16'($urandom), 0, -1, -1, 1'b0);

      // Backpressure in OUT (p=3) and in PAD (p=25).
      run_job(0, 16'h0000, 1, 3, 25, 1'b0);

      // Address wrap plus a start pulse while busy.
      run_job(0, 16'hFFFE, 0, -1, -1, 1'b1);

      // Reset in MEM2 of word 7, then a clean job.
      @(posedge clk); #1;
      start[0] = 1'b1;
      maddr_i[0] = 16'h0100;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (22) @(posedge clk);
      #1;
      check_eq("busy before reset", 32'(busy[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero(0, "midjob reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      run_job(0, 16'h0100, 0, -1, -1, 1'b0);

      // Random addresses with random consumer readiness.
      for (int k = 0; k < 3; k++) run_job(k, 16'($urandom), 2, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the simplified SHA-256 hash core. Reads a `NUM_OF_WORDS`-word message from the shared dual-port SRAM and appends SHA-256 padding in-stream. Padding is the 0x80000000 marker, zero fill and the 64-bit big-endian bit length. It emits the padded message as a valid/ready stream of 32-bit schedule words, 16 per 512-bit block, for the compression stage. It never writes memory, so the message in SRAM is left untouched.

## Interface
Parameters:
- `NUM_OF_WORDS`, default 20: message length in 32-bit words; legal range 1..2000.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset_n`  in  1: asynchronous active-low reset.
- `start`  in  1: begin job; sampled only in IDLE.
- `message_addr`  in  16: SRAM word address of message word 0; latched when start is accepted.
- `busy`  out  1: high whenever state != IDLE.
- `done`  out  1: one-cycle pulse after the last word handshake.
- `mem_clk`  out  1: equals `clk`.
- `mem_we`  out  1: constant 0.
- `mem_addr`  out  16: registered read address.
- `mem_read_data`  in  32: SRAM read data.
- `w_valid`  out  1: stream word valid.
- `w_ready`  in  1: consumer ready.
- `w_data`  out  32: padded schedule word.
- `w_index`  out  4: word position within block (0..15).
- `w_block`  out  8: block number (0..BLOCKS-1).
- `w_last`  out  1: high with the final word of the final block.

## Operation
- Derived constants:
  - BLOCKS = (NUM_OF_WORDS+2)/16 + 1 (integer division).
  - TOTAL = 16·BLOCKS.
  - SIZE = NUM_OF_WORDS·32, truncated to 32 bits.
- Global word position p runs 0..TOTAL-1; `w_block` = p[11:4], `w_index` = p[3:0].
- Word content by position:
  - p < N: `mem[message_addr+p]`, address wraps modulo 2^16.
  - p = N: 0x80000000.
  - p = TOTAL-1: SIZE.
  - All other p, including TOTAL-2 (length upper half): 0.
- States:
  - IDLE: if `start`=1, latch `message_addr`, `mem_addr`<=`message_addr`, p<=0, go to MEM1.
  - MEM1: go to MEM2. The SRAM samples `mem_addr` on this exit edge.
  - MEM2: capture `mem_read_data` into `w_data`, set `w_valid`<=1, go to OUT.
  - OUT: hold until `w_valid`&&`w_ready`. On handshake:
    - p<=p+1.
    - If p+1 < N: `mem_addr`<=`message_addr`+p+1, `w_valid`<=0, go to MEM1.
    - Otherwise: load pad word for p+1, keep `w_valid`=1, go to PAD.
  - PAD: one word per handshake, contents computed from p; `w_valid` stays 1. On the handshake with p=TOTAL-1: `w_valid`<=0, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE; no queuing.
- `w_last` = `w_valid` && (p = TOTAL-1).
- Reset, asynchronous, including mid-job: state IDLE, p=0, and all outputs 0 (`mem_addr`, `w_*`, `busy`, `done`). Any job in flight is abandoned. The consumer must discard a partial block when reset occurs.

## Timing
- Stream rules:
  - While `w_valid`=1 && `w_ready`=0, `w_data`, `w_index`, `w_block` and `w_last` hold stable.
  - `w_valid` never drops without a handshake, except on reset.
- SRAM latency: data is taken on the second rising edge after the edge that updates `mem_addr`. One outstanding read at a time.
- Cycle count, with `w_ready`=1 throughout and edge 0 the edge that accepts `start`:
  - First `w_valid` is high after edge 2.
  - Message word i handshakes at edge 3(i+1).
  - Pad word k (0-based) handshakes at edge 3N+1+k.
  - `done` is high in the cycle after edge 3N+TOTAL-N.
  - For N=20: last handshake at edge 72; `done` high between edges 72 and 73.
- Backpressure adds exactly one cycle per stalled cycle. No data is lost or duplicated.

## Test plan
- **N=20, seed 0x01234675 rotate-left-by-1 message at addr 0, `w_ready`=1:**
  - Expect 32 words; words 0..19 match memory.
  - Word 20 = 0x80000000; words 21..30 = 0; word 31 = 0x00000280.
  - `w_last` only on (block 1, index 15); `done` after edge 72.
- **N=13:**
  - BLOCKS=1; word 13 = 0x80000000, word 14 = 0, word 15 = 0x000001A0.
- **N=14:**
  - BLOCKS=2; word 14 = 0x80000000, word 15 = 0 (block 0).
  - Block 1 words 0..14 = 0; block 1 word 15 = 0x000001C0.
- **Backpressure:** N=20, `w_ready` low for 5 cycles during OUT (p=3) and during PAD (p=25).
  - Outputs stay stable while stalled.
  - Stream identical to the unstalled run; `done` 10 cycles later.
- **Address wrap and start rules:** `message_addr`=0xFFFE, N=20.
  - Reads go 0xFFFE, 0xFFFF, 0x0000, and so on.
  - A `start` pulse while busy is ignored: one `done` only.
- **Reset mid-job:** assert `reset_n`=0 at p=7 during MEM2.
  - All outputs 0 immediately.
  - After release and a new `start`, the full correct 32-word stream is produced.
